stream_demux: RTL



---
 rtl/stream_demux_pkg.sv | 25 ++
 rtl/sat_counter.sv | 23 ++
 rtl/stream_demux.sv | 106 ++++++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types, default parameters and the one-hot decode helper for stream_demux.
// Decoder vectors are sized for the largest channel count; callers cast down to N_OUT.
package stream_demux_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int N_OUT_DEF  = 8;
   localparam int CNT_W_DEF  = 16;
   localparam int N_OUT_MAX  = 256;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } demux_state_t;

   // Selects at or beyond n decode to all-zeros, so no output is ever flagged for them.
   function automatic logic [N_OUT_MAX-1:0] onehot_dec(input logic [7:0] sel, input int n);
      logic [N_OUT_MAX-1:0] v;
      v = '0;
      if (int'(sel) < n) begin
         v[sel] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: advances on inc, sticks at all-ones, clears on synchronous rst.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != {W{1'b1}})) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign q = r_cnt;

endmodule

// File: rtl/stream_demux.sv
// 1:N valid/ready stream demultiplexer with a one-entry registered output buffer.
// Define STREAM_DEMUX_STATS_EN to add per-channel pop counters and a drop counter.
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N_OUT  = N_OUT_DEF,
   parameter int SEL_W  = $clog2(N_OUT),
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic [DATA_W-1:0]      in_data,
   output logic [N_OUT-1:0]       out_valid,
   input  logic [N_OUT-1:0]       out_ready,
   output logic [DATA_W-1:0]      out_data,
`ifdef STREAM_DEMUX_STATS_EN
   output logic [N_OUT*CNT_W-1:0] stat_cnt,
   output logic [CNT_W-1:0]       drop_cnt,
`endif
   output logic                   drop
);

   demux_state_t      r_state;
   demux_state_t      w_state_next;
   logic [SEL_W-1:0]  r_sel;
   logic [SEL_W-1:0]  w_sel_next;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] w_data_next;
   logic              r_drop;
   logic              w_drop_next;

   logic              w_full;
   logic              w_pop;
   logic              w_acc;
   logic              w_in_range;

   assign w_full     = (r_state == ST_FULL);
   // Only the ready of the channel currently holding the word matters.
   assign w_pop      = w_full & out_ready[r_sel];
   assign in_ready   = ~w_full | w_pop;
   assign w_acc      = in_valid & in_ready;
   assign w_in_range = (32'(in_sel) < 32'(N_OUT));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_sel   <= '0;
         r_data  <= '0;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_sel   <= w_sel_next;
         r_data  <= w_data_next;
         r_drop  <= w_drop_next;
      end
   end

   // Gating on w_acc first keeps X on in_sel/in_data out of state while in_valid is low.
   always_comb begin
      w_state_next = r_state;
      w_sel_next   = r_sel;
      w_data_next  = r_data;
      w_drop_next  = 1'b0;
      if (w_acc && w_in_range) begin
         w_state_next = ST_FULL;
         w_sel_next   = in_sel;
         w_data_next  = in_data;
      end else begin
         if (w_pop) begin
            w_state_next = ST_EMPTY;
         end
         if (w_acc) begin
            w_drop_next = 1'b1;
         end
      end
   end

   assign out_valid = w_full ? N_OUT'(onehot_dec(8'(r_sel), N_OUT)) : '0;
   assign out_data  = r_data;
   assign drop      = r_drop;

`ifdef STREAM_DEMUX_STATS_EN
   generate
      for (genvar gi = 0; gi < N_OUT; gi++) begin : g_stat
         sat_counter #(.W(CNT_W)) u_stat (
            .clk (clk),
            .rst (rst),
            .inc (w_pop & (r_sel == SEL_W'(gi))),
            .q   (stat_cnt[gi*CNT_W +: CNT_W])
         );
      end
   endgenerate

   sat_counter #(.W(CNT_W)) u_drop_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_acc & ~w_in_range),
      .q   (drop_cnt)
   );
`endif

endmodule
